// File: rtl/mux_sel_serializer.sv
// 4-bit parallel-to-serial sequencer driving an external 4:1 mux (x data, a select), LSB first.
// Define SER_PARITY_EN to append an even-parity bit as a fifth serial bit.
module mux_sel_serializer #(
   parameter int DIV = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [3:0] x,
   output logic [1:0] a,
   input  logic       mux_out,
   output logic       ser_data,
   output logic       ser_valid,
   output logic       ser_last,
   output logic       busy
);

   // state  | meaning
   // IDLE   | waiting for a word, in_ready high
   // SHIFT  | stepping a through 0..3, sampling mux_out every DIV cycles
   // PARITY | (SER_PARITY_EN only) DIV cycles before emitting ^x

   if (DIV < 1) begin : g_div_chk
      $error("mux_sel_serializer: DIV must be >= 1");
   end

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
   typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

   state_t          state_q, state_d;
   logic [3:0]      x_q, x_d;
   logic [1:0]      a_q, a_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ser_data_q, ser_data_d;
   logic            ser_valid_q, ser_valid_d;
   logic            ser_last_q, ser_last_d;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      a_d         = a_q;
      cnt_d       = cnt_q;
      ser_data_d  = ser_data_q;
      ser_valid_d = 1'b0;
      ser_last_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d     = in_data;
               a_d     = 2'd0;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               ser_data_d  = mux_out;
               ser_valid_d = 1'b1;
               // a saturates at 3 and only returns to 0 on the next accept
               if (a_q != 2'd3) begin
                  a_d = a_q + 2'd1;
               end else begin
`ifdef SER_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d    = ST_IDLE;
                  ser_last_d = 1'b1;
`endif
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`ifdef SER_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               ser_data_d  = ^x_q;
               ser_valid_d = 1'b1;
               ser_last_d  = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         x_q         <= 4'd0;
         a_q         <= 2'd0;
         cnt_q       <= '0;
         ser_data_q  <= 1'b0;
         ser_valid_q <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         a_q         <= a_d;
         cnt_q       <= cnt_d;
         ser_data_q  <= ser_data_d;
         ser_valid_q <= ser_valid_d;
         ser_last_q  <= ser_last_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign x         = x_q;
   assign a         = a_q;
   assign ser_data  = ser_data_q;
   assign ser_valid = ser_valid_q;
   assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Bench for mux_sel_serializer: two lanes (DIV=1 and DIV=3) with ideal mux models and a timed scoreboard.
`timescale 1ns/1ps
module tb_mux_sel_serializer;

`ifdef SER_PARITY_EN
   localparam int WL  = 5;
   localparam bit PAR = 1'b1;
`else
   localparam int WL  = 4;
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      bit data;
      bit last;
      int cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   logic [3:0] in_data   [2];
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [3:0] x         [2];
   logic [1:0] a         [2];
   logic       mux_out   [2];
   logic       ser_data  [2];
   logic       ser_valid [2];
   logic       ser_last  [2];
   logic       busy      [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed %0d required %0d at cycle %0d", tag, obs, expv, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int D = (g == 0) ? 1 : 3;
      exp_t       q[$];
      exp_t       e;
      int         busy_until = -10;
      int         acc_edge   = -1;
      logic [3:0] mx         = 4'd0;
      int         ea;

      assign mux_out[g] = x[g][a[g]];

      mux_sel_serializer #(.DIV(D)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_data   (in_data[g]),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .x         (x[g]),
         .a         (a[g]),
         .mux_out   (mux_out[g]),
         .ser_data  (ser_data[g]),
         .ser_valid (ser_valid[g]),
         .ser_last  (ser_last[g]),
         .busy      (busy[g])
      );

      // reference model: accept edge number is cyc+1 (cyc updates non-blocking)
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            busy_until = -10;
            acc_edge   = -1;
            mx         = 4'd0;
            q.delete();
         end else if (in_valid[g] && cyc > busy_until) begin
            acc_edge   = cyc + 1;
            mx         = in_data[g];
            busy_until = acc_edge + WL * D - 1;
            for (int k = 0; k < 4; k++)
               q.push_back('{mx[k], (k == 3) && !PAR, acc_edge + (k + 1) * D});
            if (PAR)
               q.push_back('{^mx, 1'b1, acc_edge + 5 * D});
         end
      end

      always @(negedge clk) begin
         if (rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               chk($sformatf("d%0d_missed_bit_cycle", D), q[0].cyc, cyc);
               void'(q.pop_front());
            end
            if (ser_valid[g]) begin
               if (q.size() == 0) begin
                  chk($sformatf("d%0d_spurious_valid", D), 32'(ser_valid[g]), 0);
               end else begin
                  e = q.pop_front();
                  chk($sformatf("d%0d_ser_cycle", D), cyc, e.cyc);
                  chk($sformatf("d%0d_ser_data", D), ser_data[g], e.data);
                  chk($sformatf("d%0d_ser_last", D), ser_last[g], e.last);
               end
            end else begin
               chk($sformatf("d%0d_last_without_valid", D), ser_last[g], 0);
            end
            if (acc_edge < 0) ea = 0;
            else ea = ((cyc - acc_edge) / D > 3) ? 3 : (cyc - acc_edge) / D;
            chk($sformatf("d%0d_in_ready", D), in_ready[g], cyc > busy_until);
            chk($sformatf("d%0d_busy", D), busy[g], cyc <= busy_until);
            chk($sformatf("d%0d_a", D), a[g], ea);
            chk($sformatf("d%0d_x", D), x[g], mx);
         end
      end
   end

   task automatic check_reset(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s%0d_x", tag, i), x[i], 0);
         chk($sformatf("%s%0d_a", tag, i), a[i], 0);
         chk($sformatf("%s%0d_ser_data", tag, i), ser_data[i], 0);
         chk($sformatf("%s%0d_ser_valid", tag, i), ser_valid[i], 0);
         chk($sformatf("%s%0d_ser_last", tag, i), ser_last[i], 0);
         chk($sformatf("%s%0d_busy", tag, i), busy[i], 0);
         chk($sformatf("%s%0d_in_ready", tag, i), in_ready[i], 1);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] d0, input logic [3:0] d1);
      in_valid[0] = v;
      in_valid[1] = v;
      in_data[0]  = d0;
      in_data[1]  = d1;
   endtask

   initial begin
      drive(1'b0, 4'd0, 4'd0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("por");
      #1 rst_n = 1'b1;

      // idle stability
      repeat (20) @(negedge clk);

      // basic serialization on both lanes
      #1 drive(1'b1, 4'b1011, 4'b0110);
      @(negedge clk);
      #1 drive(1'b0, 4'd0, 4'd0);
      repeat (25) @(negedge clk);

      // hold-off: in_valid stuck high, data changing every cycle
      for (int i = 0; i < 40; i++) begin
         #1 drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         @(negedge clk);
      end
      #1 drive(1'b0, 4'd0, 4'd0);
      repeat (25) @(negedge clk);

      // reset between bit 1 and bit 2 of the DIV=1 lane
      #1 drive(1'b1, 4'b0101, 4'b0101);
      @(negedge clk);
      #1 drive(1'b0, 4'd0, 4'd0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("abort");
      drive(1'b1, 4'b1111, 4'b1111);
      repeat (2) @(negedge clk);
      check_reset("held");
      #2 rst_n = 1'b1;
      @(negedge clk);
      #1 drive(1'b0, 4'd0, 4'd0);
      repeat (30) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
